// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port numbering, output-port FSM states and
// the select-width helper used by the crossbar output port and its arbiter.
package noc_pkg;

   localparam int PORT_N   = 0;
   localparam int PORT_S   = 1;
   localparam int PORT_W   = 2;
   localparam int PORT_E   = 3;
   localparam int PORT_L   = 4;
   localparam int NUM_DIRS = 5;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req_i starting one past
// last_grant_i, wrapping at N, and returns the winner one-hot and as an index.
module rr_arbiter
   import noc_pkg::*;
#(
   parameter  int N     = NUM_DIRS,
   localparam int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [SEL_W-1:0] last_grant_i,
   output logic [N-1:0]     grant_o,
   output logic [SEL_W-1:0] grant_idx_o
);

   int   w_idx;
   logic w_found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      w_found     = 1'b0;
      w_idx       = 0;
      for (int i = 1; i <= N; i++) begin
         // last_grant_i < N, so a single subtraction is enough to wrap
         w_idx = int'(last_grant_i) + i;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end
         if (!w_found && req_i[w_idx]) begin
            w_found          = 1'b1;
            grant_o[w_idx]   = 1'b1;
            grant_idx_o      = SEL_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/xbar_out_port.sv
// Crossbar output port: round-robin picks an input, holds it until the tail
// flit, and forwards flits through a single registered output stage.
//
// state  | meaning
// IDLE   | no owner; arbiter picks among valid inputs each cycle
// LOCKED | r_sel owns the output mid-packet; other inputs are ignored
module xbar_out_port
   import noc_pkg::*;
#(
   parameter  int NUM_PORTS = NUM_DIRS,
   parameter  int DATA_W    = 16,
   localparam int SEL_W     = sel_width(NUM_PORTS)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NUM_PORTS-1:0]             valid_i,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0] data_i,
   input  logic [NUM_PORTS-1:0]             tail_i,
   output logic [NUM_PORTS-1:0]             ready_o,
   output logic                             valid_o,
   output logic [DATA_W-1:0]                data_o,
   output logic                             tail_o,
   output logic [SEL_W-1:0]                 sel_o,
   input  logic                             ready_i
);

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [SEL_W-1:0]        r_sel;
   logic [SEL_W-1:0]        r_last_grant;
   logic                    r_valid;
   logic [DATA_W-1:0]       r_data;
   logic                    r_tail;

   logic [NUM_PORTS-1:0]    w_arb_grant;
   logic [SEL_W-1:0]        w_arb_idx;
   logic [NUM_PORTS-1:0]    w_owner_oh;
   logic [NUM_PORTS-1:0]    w_ready;
   logic [SEL_W-1:0]        w_src_idx;
   logic [DATA_W-1:0]       w_src_data;
   logic                    w_src_tail;
   logic                    w_load_en;
   logic                    w_xfer;

   rr_arbiter #(
      .N (NUM_PORTS)
   ) u_arb (
      .req_i        (valid_i),
      .last_grant_i (r_last_grant),
      .grant_o      (w_arb_grant),
      .grant_idx_o  (w_arb_idx)
   );

   always_comb begin
      w_state_nxt       = r_state;
      w_ready           = '0;
      w_src_idx         = r_sel;
      w_owner_oh        = '0;
      w_owner_oh[r_sel] = 1'b1;
      w_load_en         = !r_valid || ready_i;

      case (r_state)
         IDLE: begin
            w_ready   = w_arb_grant & {NUM_PORTS{w_load_en}};
            w_src_idx = w_arb_idx;
         end
         LOCKED: begin
            w_ready   = w_owner_oh & {NUM_PORTS{w_load_en}};
         end
         default: begin
            w_ready   = '0;
         end
      endcase

      // ready must drop the moment reset rises, not at the next edge
      if (rst_i) begin
         w_ready = '0;
      end

      w_xfer     = |(valid_i & w_ready);
      w_src_data = data_i[w_src_idx];
      w_src_tail = tail_i[w_src_idx];

      case (r_state)
         IDLE:    if (w_xfer && !w_src_tail) w_state_nxt = LOCKED;
         LOCKED:  if (w_xfer && w_src_tail)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_sel        <= '0;
         r_last_grant <= SEL_W'(NUM_PORTS - 1);
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_xfer) begin
            r_sel        <= w_arb_idx;
            r_last_grant <= w_arb_idx;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tail  <= 1'b0;
      end else if (w_load_en) begin
         r_valid <= w_xfer;
         if (w_xfer) begin
            r_data <= w_src_data;
            r_tail <= w_src_tail;
         end
      end
   end

   assign ready_o = w_ready;
   assign valid_o = r_valid;
   assign data_o  = r_data;
   assign tail_o  = r_tail;
   assign sel_o   = r_sel;

endmodule

// File: tb/tb_xbar_out_port.sv
// Scoreboard bench for xbar_out_port: per-port flit sources feed the DUT,
// expected output flits are queued by each test and popped on output handshakes.
module tb_xbar_out_port;
   import noc_pkg::*;

   localparam int NP = NUM_DIRS;
   localparam int DW = 16;
   localparam int SW = 3;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic [NP-1:0]        valid_i;
   logic [NP-1:0][DW-1:0] data_i;
   logic [NP-1:0]        tail_i;
   logic [NP-1:0]        ready_o;
   logic                 valid_o;
   logic [DW-1:0]        data_o;
   logic                 tail_o;
   logic [SW-1:0]        sel_o;
   logic                 ready_i;

   logic [7:0]           valid2;
   logic [7:0][31:0]     data2;
   logic [7:0]           tail2;
   logic [7:0]           ready_o2;
   logic                 valid_o2;
   logic [31:0]          data_o2;
   logic                 tail_o2;
   logic [2:0]           sel_o2;
   logic                 ready_i2;

   always #5 clk_i = ~clk_i;

   xbar_out_port #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .tail_i  (tail_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .tail_o  (tail_o),
      .sel_o   (sel_o),
      .ready_i (ready_i)
   );

   xbar_out_port #(.NUM_PORTS(8), .DATA_W(32)) dut8 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid2),
      .data_i  (data2),
      .tail_i  (tail2),
      .ready_o (ready_o2),
      .valid_o (valid_o2),
      .data_o  (data_o2),
      .tail_o  (tail_o2),
      .sel_o   (sel_o2),
      .ready_i (ready_i2)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [16:0]  src_mem [NP][16];
   int           src_wr  [NP];
   int           src_rd  [NP];
   logic [NP-1:0] hold_mask;
   logic [19:0]  exp_q [$];
   int           steps;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_src(input int p, input logic [15:0] d, input logic t);
      src_mem[p][src_wr[p]] = {t, d};
      src_wr[p]++;
   endtask

   task automatic push_exp(input int p, input logic [15:0] d, input logic t);
      exp_q.push_back({3'(p), t, d});
   endtask

   task automatic clear_all();
      for (int p = 0; p < NP; p++) begin
         src_wr[p] = 0;
         src_rd[p] = 0;
      end
      hold_mask = '0;
      exp_q.delete();
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         if (src_rd[p] < src_wr[p] && !hold_mask[p]) begin
            valid_i[p] = 1'b1;
            data_i[p]  = src_mem[p][src_rd[p]][15:0];
            tail_i[p]  = src_mem[p][src_rd[p]][16];
         end else begin
            valid_i[p] = 1'b0;
            data_i[p]  = '0;
            tail_i[p]  = 1'b0;
         end
      end
      #1;
   endtask

   // One clock: score the output at the negedge, advance sources after the edge.
   task automatic step();
      logic [NP-1:0] acc;
      logic [19:0]   e;
      @(negedge clk_i);
      acc = valid_i & ready_o;
      if (valid_o && ready_i) begin
         chk("exp_avail", 64'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_flit", 64'({sel_o, tail_o, data_o}), 64'(e));
         end
      end
      @(posedge clk_i);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (acc[p]) src_rd[p]++;
      end
      drive();
   endtask

   task automatic run_drain(input string tag, input int max, output int n);
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         step();
         n++;
      end
      chk(tag, 64'(exp_q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i    = 1'b1;
      ready_i  = 1'b0;
      ready_i2 = 1'b1;
      valid_i  = '1;
      tail_i   = '1;
      for (int p = 0; p < NP; p++) data_i[p] = 16'h5A00 + 16'(p);
      valid2   = '0;
      tail2    = '0;
      data2    = '0;
      clear_all();

      // reset values, with every input requesting
      #12;
      chk("rst_valid", 64'(valid_o), 0);
      chk("rst_data",  64'(data_o), 0);
      chk("rst_tail",  64'(tail_o), 0);
      chk("rst_sel",   64'(sel_o), 0);
      chk("rst_ready", 64'(ready_o), 0);
      chk("rst_sel8",  64'(sel_o2), 0);
      drive();
      @(posedge clk_i);
      #1;
      rst_i   = 1'b0;
      ready_i = 1'b1;

      repeat (2) begin
         step();
         chk("idle_ready", 64'(ready_o), 0);
         chk("idle_valid", 64'(valid_o), 0);
      end

      // round robin over single-flit packets, sustained one flit per cycle
      for (int r = 1; r <= 2; r++) begin
         for (int p = 0; p < NP; p++) begin
            push_src(p, 16'(r * 256 + p), 1'b1);
            push_exp(p, 16'(r * 256 + p), 1'b1);
         end
      end
      drive();
      run_drain("rr_drain", 30, steps);
      chk("rr_cycles", 64'(steps), 11);

      // port W owns the output for a 3-flit packet while port N waits
      push_src(PORT_W, 16'hA001, 1'b0);
      push_src(PORT_W, 16'hA002, 1'b0);
      push_src(PORT_W, 16'hA003, 1'b1);
      push_exp(PORT_W, 16'hA001, 1'b0);
      push_exp(PORT_W, 16'hA002, 1'b0);
      push_exp(PORT_W, 16'hA003, 1'b1);
      drive();
      step();
      push_src(PORT_N, 16'hB000, 1'b1);
      push_exp(PORT_N, 16'hB000, 1'b1);
      drive();
      chk("lock_ready", 64'(ready_o), 64'(5'b00100));
      chk("lock_sel",   64'(sel_o), 64'(PORT_W));
      run_drain("lock_drain", 20, steps);
      chk("lock_cycles", 64'(steps), 4);

      // downstream stall holds the output register
      push_src(PORT_S, 16'h1234, 1'b1);
      push_src(PORT_E, 16'h5678, 1'b1);
      push_exp(PORT_S, 16'h1234, 1'b1);
      push_exp(PORT_E, 16'h5678, 1'b1);
      drive();
      step();
      ready_i = 1'b0;
      #1;
      repeat (3) begin
         step();
         chk("bp_data",  64'(data_o), 64'(16'h1234));
         chk("bp_valid", 64'(valid_o), 1);
         chk("bp_ready", 64'(ready_o), 0);
      end
      ready_i = 1'b1;
      step();
      chk("bp_next", 64'({valid_o, data_o}), 64'({1'b1, 16'h5678}));
      run_drain("bp_drain", 5, steps);

      // owner goes quiet mid-packet: bubbles, other ports stay blocked
      push_src(PORT_L, 16'hC001, 1'b0);
      push_src(PORT_L, 16'hC002, 1'b0);
      push_src(PORT_L, 16'hC003, 1'b1);
      push_src(PORT_S, 16'hD001, 1'b1);
      push_exp(PORT_L, 16'hC001, 1'b0);
      push_exp(PORT_L, 16'hC002, 1'b0);
      push_exp(PORT_L, 16'hC003, 1'b1);
      push_exp(PORT_S, 16'hD001, 1'b1);
      drive();
      step();
      step();
      hold_mask[PORT_L] = 1'b1;
      drive();
      repeat (2) begin
         step();
         chk("bub_valid", 64'(valid_o), 0);
         chk("bub_sel",   64'(sel_o), 64'(PORT_L));
         chk("bub_ready", 64'(ready_o), 64'(5'b10000));
      end
      hold_mask = '0;
      drive();
      run_drain("bub_drain", 10, steps);

      // asynchronous reset in the middle of a packet
      push_src(PORT_N, 16'hE001, 1'b0);
      push_src(PORT_N, 16'hE002, 1'b0);
      push_src(PORT_N, 16'hE003, 1'b1);
      push_exp(PORT_N, 16'hE001, 1'b0);
      push_exp(PORT_N, 16'hE002, 1'b0);
      push_exp(PORT_N, 16'hE003, 1'b1);
      drive();
      step();
      step();
      chk("ar_pre_valid", 64'(valid_o), 1);
      rst_i = 1'b1;
      #1;
      chk("ar_valid", 64'(valid_o), 0);
      chk("ar_data",  64'(data_o), 0);
      chk("ar_sel",   64'(sel_o), 0);
      chk("ar_ready", 64'(ready_o), 0);
      clear_all();
      drive();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      repeat (3) begin
         step();
         chk("post_rst_valid", 64'(valid_o), 0);
      end

      // first pick after reset must be port N
      push_src(PORT_E, 16'h6003, 1'b1);
      push_src(PORT_N, 16'h6000, 1'b1);
      push_exp(PORT_N, 16'h6000, 1'b1);
      push_exp(PORT_E, 16'h6003, 1'b1);
      drive();
      run_drain("prio_drain", 10, steps);

      // 8-port instance: pointer wraps 7 -> 0
      for (int p = 0; p < 8; p++) data2[p] = 32'hC0DE_0000 + 32'(p);
      tail2  = '1;
      valid2 = 8'h81;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i);
         #1;
         chk("wrap_valid", 64'(valid_o2), 1);
         chk("wrap_sel",   64'(sel_o2), (k % 2 == 1) ? 7 : 0);
         chk("wrap_data",  64'(data_o2), (k % 2 == 1) ? 64'h0000_0000_C0DE_0007
                                                       : 64'h0000_0000_C0DE_0000);
      end
      valid2 = '0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/xbar_out_port.md
XBAR_OUT_PORT -- requirements
Module: xbar_out_port

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of input ports (N,S,W,E,L order), range 2..8.
REQ-002 Parameter DATA_W, default 16, flit width in bits.
REQ-003 Derived SEL_W = max(1, clog2(NUM_PORTS)).
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 valid_i  input  NUM_PORTS  per-port flit valid.
REQ-007 data_i  input  NUM_PORTS x DATA_W  per-port flit payload.
REQ-008 tail_i  input  NUM_PORTS  per-port last-flit-of-packet flag.
REQ-009 ready_o  output  NUM_PORTS  per-port accept, one-hot or zero.
REQ-010 valid_o  output  1  registered output flit valid.
REQ-011 data_o  output  DATA_W  registered output payload.
REQ-012 tail_o  output  1  registered tail flag.
REQ-013 sel_o  output  SEL_W  index of port currently owning the output.
REQ-014 ready_i  input  1  downstream accept.

Function
REQ-015 Transfer on input p occurs when valid_i[p] and ready_o[p] both high on a clock edge.
REQ-016 Output register can load (load_en) when valid_o is 0 or ready_i is 1.
REQ-017 FSM states: IDLE (no owner) and LOCKED (owner = sel_o, mid-packet).
REQ-018 IDLE: round-robin pick among valid_i starting at (last_grant+1) mod NUM_PORTS; ready_o = one-hot of pick gated by load_en.
REQ-019 IDLE, transfer of non-tail flit: go LOCKED, sel_o and last_grant <= picked index.
REQ-020 IDLE, transfer of tail flit (single-flit packet): stay IDLE, sel_o and last_grant <= picked index.
REQ-021 LOCKED: ready_o[sel_o] = load_en, all other ready_o 0; other ports' valid_i ignored.
REQ-022 LOCKED, tail transfer: go IDLE next cycle; owner drops valid mid-packet: stay LOCKED, emit bubbles.
REQ-023 Latency exactly 1 cycle: flit transferred at edge t drives data_o/tail_o with valid_o=1 after edge t.
REQ-024 load_en high with no transfer: valid_o <= 0; data_o/tail_o hold.
REQ-025 valid_o high and ready_i low: data_o, tail_o, valid_o held stable, all ready_o 0.
REQ-026 No valid_i in IDLE: ready_o all 0, state, pointer unchanged.
REQ-027 Pointer wrap: last_grant = NUM_PORTS-1 searches from port 0.
REQ-028 Full throughput: with ready_i held 1, one flit per cycle sustained, including back-to-back packets from different ports.

Reset
REQ-029 rst_i high forces immediately: valid_o=0, data_o=0, tail_o=0, sel_o=0, state IDLE, last_grant=NUM_PORTS-1, ready_o=0.
REQ-030 Reset mid-packet discards the partial packet; no flit from before reset appears after release.
REQ-031 First edge after release behaves as IDLE with port 0 highest priority.

Structure
REQ-032 Shared package noc_pkg holds port index constants (PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_L=4), NUM_DIRS=5 and the state enum (IDLE, LOCKED).
REQ-033 Round-robin arbiter is sub-module rr_arbiter (parameter N; inputs req, last_grant; outputs grant one-hot, grant index), purely combinational.
REQ-034 Payload selection uses an indexed mux over data_i by grant index; no x-assignment on any output.

Verification
REQ-035 Reset: assert rst_i mid-cycle with valid_o=1 -> valid_o, data_o, sel_o go 0 without a clock edge.
REQ-036 Round-robin: valid_i=5'b11111, all tail=1, ready_i=1 -> sel_o sequence 0,1,2,3,4,0; data_o follows with 1-cycle latency.
REQ-037 Lock: port 2 sends 3 flits 0xA001,0xA002,0xA003(tail) while port 0 valid -> output A001,A002,A003 consecutive, then port 0 flit.
REQ-038 Backpressure: ready_i=0 for 3 cycles with valid_o=1, data_o=0x1234 -> data_o stable 0x1234, ready_o=0; released -> next flit 1 cycle later.
REQ-039 Bubble: locked port 4 drops valid_i for 2 cycles mid-packet, port 1 valid -> valid_o=0 for 2 cycles, ready_o[1]=0, sel_o=4.
REQ-040 Parameters NUM_PORTS=8, DATA_W=32: pointer wrap from 7 to 0 verified with valid_i=8'h81.
